// File: rtl/mem_view_pipeline.sv
`timescale 1ns/1ps
// mem_view_pipeline: maps VGA raster coordinates onto NoC core data memory.
// For each visible pixel one peek is issued, the returned word is coloured
// according to the active mode, and the syncs are delayed to stay aligned.
module mem_view_pipeline #(
  parameter int CORE_W       = 4,
  parameter int ADDR_W       = 32,
  parameter int WORDS_LOG2   = 10,
  parameter int FIRST_CORE   = 6,
  parameter int NUM_CORES    = 5,
  parameter int VIEW_W       = 48,
  parameter int VIEW_H       = 88,
  parameter int SCALE_LOG2   = 0,
  parameter int PEEK_LATENCY = 0,
  parameter int IDLE_ID      = 15,
  parameter bit SYNC_IDLE    = 1'b1
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic [10:0]       x_coord,
  input  logic [10:0]       y_coord,
  input  logic              canDisplay,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [1:0]        mode,
  input  logic [2:0]        shift,
  output logic [CORE_W-1:0] peekId,
  output logic [ADDR_W-1:0] peekAddress,
  input  logic [31:0]       peekData,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hs,
  output logic              vs,
  output logic [15:0]       frame_cnt
);
  // Total latency from raster inputs to the colour register.
  localparam int L    = 2 + PEEK_LATENCY;
  localparam int NPIX = NUM_CORES << WORDS_LOG2;

  logic [31:0] px, py, n;
  logic        in_view;

  // Stage A address math: scaled coordinates, linear index and view test.
  always_comb begin
    px      = 32'(x_coord >> SCALE_LOG2);
    py      = 32'(y_coord >> SCALE_LOG2);
    n       = px + py * 32'(VIEW_W);
    in_view = canDisplay && (px < 32'(VIEW_W)) && (py < 32'(VIEW_H)) && (n < 32'(NPIX));
  end

  // Stage A register: the core index is the upper bits of n, the address the lower bits.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      peekId      <= CORE_W'(IDLE_ID);
      peekAddress <= '0;
    end else if (in_view) begin
      peekId      <= CORE_W'(FIRST_CORE) + CORE_W'(n >> WORDS_LOG2);
      peekAddress <= ADDR_W'(n & ((32'd1 << WORDS_LOG2) - 32'd1));
    end else begin
      peekId      <= CORE_W'(IDLE_ID);
      peekAddress <= '0;
    end
  end

  // Per-pixel side information and syncs. in_view already includes canDisplay,
  // so one valid bit covers both blanking conditions; only the parity of the
  // core offset is needed downstream (core-map colouring).
  logic [L-1:0] hs_pipe, vs_pipe;
  logic [L-2:0] vld_pipe, par_pipe;

  // Delay lines: syncs run L stages, pixel info runs up to the colour stage.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe  <= {L{SYNC_IDLE}};
      vs_pipe  <= {L{SYNC_IDLE}};
      vld_pipe <= '0;
      par_pipe <= '0;
    end else begin
      hs_pipe[0]  <= hs_in;
      vs_pipe[0]  <= vs_in;
      vld_pipe[0] <= in_view;
      par_pipe[0] <= n[WORDS_LOG2];
      for (int i = 1; i < L; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
      for (int i = 1; i <= L-2; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        par_pipe[i] <= par_pipe[i-1];
      end
    end
  end

  assign hs = hs_pipe[L-1];
  assign vs = vs_pipe[L-1];

  logic       vs_d;
  logic       fall;
  logic [1:0] mode_act;
  logic [2:0] shift_act;

  assign fall = vs_d & ~vs_in;

  // Frame boundary: latch mode/shift and count frames on the falling edge of vs_in.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      vs_d      <= SYNC_IDLE;
      mode_act  <= 2'd0;
      shift_act <= 3'd0;
      frame_cnt <= 16'd0;
    end else begin
      vs_d <= vs_in;
      if (fall) begin
        mode_act  <= mode;
        shift_act <= shift;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  logic [31:0] v;
  logic [7:0]  s8;
  logic [23:0] rgb_n;

  // Colour stage: saturating brightness, then the active colour mode, then blanking.
  always_comb begin
    v  = peekData >> shift_act;
    s8 = (|v[31:8]) ? 8'hFF : v[7:0];
    case (mode_act)
      2'd0:    rgb_n = {s8, s8, s8};
      2'd1:    rgb_n = {s8, (s8[7] ? {s8[6:0], 1'b0} : 8'h00), ~s8};
      2'd2:    rgb_n = peekData[23:0];
      default: rgb_n = par_pipe[L-2] ? 24'h0000FF : 24'hFF0000;
    endcase
    if (!vld_pipe[L-2]) rgb_n = 24'h0;
  end

  // Colour register.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) {r, g, b} <= 24'h0;
    else        {r, g, b} <= rgb_n;
  end
endmodule

// File: tb/tb_mem_view_pipeline.sv
`timescale 1ns/1ps
// Bench for mem_view_pipeline: two instances (default parameters and
// PEEK_LATENCY=3/SCALE_LOG2=1) driven by the same raster, each checked every
// cycle against a per-cycle reference model built from the raster rules.
module tb_mem_view_pipeline;
  localparam int NC = 3000;

  typedef struct packed {
    logic [10:0] x, y;
    logic        cd, hs, vs;
    logic [1:0]  mode;
    logic [2:0]  shift;
    logic        fe;
    logic [31:0] fv;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic [10:0] x_coord = '0, y_coord = '0;
  logic        canDisplay = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [1:0]  mode = '0;
  logic [2:0]  shift = '0;
  logic        fe = 1'b0;
  logic [31:0] fv = '0;

  logic [3:0]  id0, id1;
  logic [31:0] ad0, ad1, pd0, pd1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, hs1, vs1;
  logic [15:0] fc0, fc1;

  mem_view_pipeline d0 (
    .clk_25mhz(clk), .rst_n(rst_n), .x_coord(x_coord), .y_coord(y_coord),
    .canDisplay(canDisplay), .hs_in(hs_in), .vs_in(vs_in), .mode(mode), .shift(shift),
    .peekId(id0), .peekAddress(ad0), .peekData(pd0), .r(r0), .g(g0), .b(b0),
    .hs(hs0), .vs(vs0), .frame_cnt(fc0));

  mem_view_pipeline #(.PEEK_LATENCY(3), .SCALE_LOG2(1)) d1 (
    .clk_25mhz(clk), .rst_n(rst_n), .x_coord(x_coord), .y_coord(y_coord),
    .canDisplay(canDisplay), .hs_in(hs_in), .vs_in(vs_in), .mode(mode), .shift(shift),
    .peekId(id1), .peekAddress(ad1), .peekData(pd1), .r(r1), .g(g1), .b(b1),
    .hs(hs1), .vs(vs1), .frame_cnt(fc1));

  // Core memory contents: an arbitrary scrambled function of (core, address).
  function automatic logic [31:0] memf(logic [3:0] id, logic [31:0] a);
    logic [31:0] h;
    h = {id, a[27:0]} * 32'h9E3779B1;
    h = h ^ (h >> 15);
    if (h[31]) h = h >> h[4:0];
    return h;
  endfunction

  // Memory side of the NoC: combinational for d0, three cycles deep for d1.
  logic [35:0] rq1a = '0, rq1b = '0, rq1c = '0;
  always @(posedge clk) begin
    rq1a <= {id1, ad1};
    rq1b <= rq1a;
    rq1c <= rq1b;
  end
  assign pd0 = fe ? fv : memf(id0, ad0);
  assign pd1 = fe ? fv : memf(rq1c[35:32], rq1c[31:0]);

  in_t        hist [0:NC-1];
  int         fcnt [0:NC-1];
  logic [1:0] am   [0:NC];
  logic [2:0] ash  [0:NC];
  int t = 1, t0 = 1;
  int n_tests = 0, n_fail = 0;
  logic [1:0] cm = '0;
  logic [2:0] cs = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic in_t dflt();
    in_t s = '0;
    s.hs = 1'b1;
    s.vs = 1'b1;
    return s;
  endfunction

  function automatic in_t inp(int i);
    if (i < t0 || i < 0) return dflt();
    return hist[i];
  endfunction

  // Linear source-pixel index, or -1 when the pixel is outside the view.
  function automatic int pix_n(in_t s, int sc);
    int px, py, n;
    px = int'(s.x) / (1 << sc);
    py = int'(s.y) / (1 << sc);
    if (!s.cd || px >= 48 || py >= 88) return -1;
    n = px + py * 48;
    if (n >= 5 * 1024) return -1;
    return n;
  endfunction

  // Expected colour register after edge e for an instance of latency 2+pl.
  function automatic logic [23:0] exp_rgb(int sc, int pl, int e);
    int n, s8, gg;
    in_t cur;
    logic [31:0] data, vv;
    n = pix_n(inp(e - (2 + pl) + 1), sc);
    if (n < 0) return 24'h0;
    cur  = inp(e);
    data = cur.fe ? cur.fv : memf(4'(6 + n / 1024), 32'(n % 1024));
    vv   = data >> ash[e];
    s8   = (vv > 255) ? 255 : int'(vv);
    gg   = (s8 >= 128) ? (s8 - 128) * 2 : 0;
    case (am[e])
      2'd0:    return {8'(s8), 8'(s8), 8'(s8)};
      2'd1:    return {8'(s8), 8'(gg), 8'(255 - s8)};
      2'd2:    return data[23:0];
      default: return ((n / 1024) % 2 == 0) ? 24'hFF0000 : 24'h0000FF;
    endcase
  endfunction

  task automatic chk_dut(string nm, int sc, int pl, logic [3:0] id, logic [31:0] ad,
                         logic [7:0] rr, logic [7:0] gg, logic [7:0] bb,
                         logic h, logic v, logic [15:0] fc);
    int e, n, p;
    e = t - 1;
    n = pix_n(inp(e), sc);
    p = e - (2 + pl) + 1;
    chk({nm, ".id"}, 32'(id), (n < 0) ? 32'd15 : 32'(6 + n / 1024));
    chk({nm, ".addr"}, ad, (n < 0) ? 32'd0 : 32'(n % 1024));
    chk({nm, ".rgb"}, 32'({rr, gg, bb}), 32'(exp_rgb(sc, pl, e)));
    chk({nm, ".hs"}, 32'(h), 32'(inp(p).hs));
    chk({nm, ".vs"}, 32'(v), 32'(inp(p).vs));
    chk({nm, ".fcnt"}, 32'(fc), 32'(fcnt[e] & 16'hFFFF));
  endtask

  task automatic drive(in_t s);
    x_coord = s.x; y_coord = s.y; canDisplay = s.cd; hs_in = s.hs; vs_in = s.vs;
    mode = s.mode; shift = s.shift; fe = s.fe; fv = s.fv;
  endtask

  // One raster cycle: check the outputs of the previous edge, then drive new inputs.
  task automatic cyc(in_t s);
    bit fall;
    @(negedge clk);
    chk_dut("d0", 0, 0, id0, ad0, r0, g0, b0, hs0, vs0, fc0);
    chk_dut("d1", 1, 3, id1, ad1, r1, g1, b1, hs1, vs1, fc1);
    if (t >= NC) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", t, NC);
      $fatal(1, "cycle budget exhausted");
    end
    hist[t] = s;
    drive(s);
    fall      = inp(t - 1).vs && !s.vs;
    fcnt[t]   = fcnt[t-1] + (fall ? 1 : 0);
    am[t+1]   = fall ? s.mode  : am[t];
    ash[t+1]  = fall ? s.shift : ash[t];
    t++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(dflt());
    #1;
    chk("rst.d0.id", 32'(id0), 32'd15);   chk("rst.d0.addr", ad0, 32'd0);
    chk("rst.d0.rgb", 32'({r0, g0, b0}), 32'd0);
    chk("rst.d0.sync", 32'({hs0, vs0}), 32'd3); chk("rst.d0.fcnt", 32'(fc0), 32'd0);
    chk("rst.d1.id", 32'(id1), 32'd15);   chk("rst.d1.addr", ad1, 32'd0);
    chk("rst.d1.rgb", 32'({r1, g1, b1}), 32'd0);
    chk("rst.d1.sync", 32'({hs1, vs1}), 32'd3); chk("rst.d1.fcnt", 32'(fc1), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    t0 = t;
    fcnt[t0-1] = 0;
    am[t0] = 2'd0;
    ash[t0] = 3'd0;
  endtask

  function automatic in_t mk(int x, int y, bit cd, bit h, bit v, bit f, logic [31:0] val);
    in_t s;
    s.x = 11'(x); s.y = 11'(y); s.cd = cd; s.hs = h; s.vs = v;
    s.mode = cm; s.shift = cs; s.fe = f; s.fv = val;
    return s;
  endfunction

  function automatic in_t pix(int x, int y);
    return mk(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
  endfunction

  function automatic in_t idle(bit f = 1'b0, logic [31:0] val = 32'd0);
    return mk(0, 0, 1'b0, 1'b1, 1'b1, f, val);
  endfunction

  task automatic frame();
    cyc(mk(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    cyc(idle());
  endtask

  logic [31:0] t4_in  [0:2] = '{32'h1000, 32'h3FC, 32'h3F8};
  logic [23:0] t4_exp [0:2] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFEFEFE};

  initial begin
    do_reset();

    // Defaults applied at the first frame boundary, then pixel (0,0).
    cyc(idle()); frame();
    cyc(pix(0, 0)); cyc(idle(1'b1, 32'h50));
    chk("t1.id", 32'(id0), 32'd6); chk("t1.addr", ad0, 32'd0);
    cyc(idle());
    chk("t1.rgb", 32'({r0, g0, b0}), 32'h505050);

    // Core boundary inside row 21.
    cyc(pix(16, 21)); cyc(pix(15, 21));
    chk("t2.id_a", 32'(id0), 32'd7); chk("t2.addr_a", ad0, 32'd0);
    cyc(idle());
    chk("t2.id_b", 32'(id0), 32'd6); chk("t2.addr_b", ad0, 32'd1023);

    // Outside the view.
    cyc(pix(48, 0)); cyc(idle());
    chk("t3.id_x", 32'(id0), 32'd15); chk("t3.addr_x", ad0, 32'd0);
    cyc(pix(0, 88)); cyc(idle());
    chk("t3.id_y", 32'(id0), 32'd15);
    cyc(mk(1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0)); cyc(idle());
    chk("t3.id_cd", 32'(id0), 32'd15);

    // Saturating brightness with shift=2.
    cs = 3'd2; frame();
    for (int i = 0; i < 3; i++) begin
      cyc(pix(1, 1)); cyc(idle(1'b1, t4_in[i])); cyc(idle());
      chk("t4.rgb", 32'({r0, g0, b0}), 32'(t4_exp[i]));
    end

    // Mode change mid-frame has no effect until the next boundary.
    cm = 2'd2;
    cyc(pix(2, 2)); cyc(idle(1'b1, 32'h00123456)); cyc(idle());
    chk("t5.rgb_old", 32'({r0, g0, b0}), 32'hFFFFFF);
    frame();
    chk("t5.fcnt", 32'(fc0), 32'd3);
    cyc(pix(2, 2)); cyc(idle(1'b1, 32'h00123456)); cyc(idle());
    chk("t5.rgb_new", 32'({r0, g0, b0}), 32'h123456);

    // Scaled instance: addressing and sync lag.
    cyc(pix(2, 0)); cyc(idle());
    chk("t6.addr_a", ad1, 32'd1);
    cyc(pix(3, 1)); cyc(idle());
    chk("t6.addr_b", ad1, 32'd1);
    cyc(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
    repeat (4) cyc(idle());
    chk("t6.hs_pre", 32'(hs1), 32'd1);
    cyc(idle());
    chk("t6.hs_lag", 32'(hs1), 32'd0);
    cyc(pix(5, 5)); cyc(pix(6, 5));
    do_reset();

    // Randomized raster with occasional frame boundaries and one mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      in_t s;
      if ($urandom % 40 == 0) begin
        cm = 2'($urandom);
        cs = 3'($urandom);
      end
      s = mk(int'($urandom % 120), int'($urandom % 200), ($urandom % 8) != 0,
             1'($urandom), ($urandom % 60) != 0, ($urandom % 10) == 0,
             $urandom >> ($urandom % 32));
      if (i == 1000) do_reset();
      cyc(s);
    end
    cyc(idle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
